// File: rtl/mpu_pkg.sv
// Shared MPU widths, store-writer FSM encoding and slot sizing.
// Other modules import this package, so these values set the widths of the whole store path.
package mpu_pkg;
    localparam int FPBITS          = 15;
    localparam int MBITS           = 3;
    localparam int NBITS           = 3;
    localparam int MATRIX_REG_BITS = 2;
    localparam int STORE_TOTAL_W   = MBITS + NBITS + 2;
    localparam int STORE_SLOT_WORDS = 64;

    typedef enum logic [1:0] {
        SW_IDLE   = 2'd0,
        SW_STREAM = 2'd1,
        SW_DRAIN  = 2'd2,
        SW_DONE   = 2'd3
    } store_wr_state_t;

    function automatic logic [STORE_TOTAL_W-1:0] store_total(
        input logic [MBITS:0] m,
        input logic [NBITS:0] n
    );
        return STORE_TOTAL_W'(m) * STORE_TOTAL_W'(n);
    endfunction
endpackage

// File: rtl/mpu_sync_fifo.sv
// Synchronous FIFO with registered head data; latency: push to non-empty 1 cycle.
// Backpressure: a push while full is dropped unless the same cycle pops.
module mpu_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign rd_ptr_nxt = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
            // The incoming word becomes the head only when the FIFO would otherwise be empty.
            if (push_ok && (wr_ptr == rd_ptr_nxt)) rd_data <= push_data;
            else                                   rd_data <= mem[rd_ptr_nxt];
        end
    end
endmodule

// File: rtl/mpu_store_writer.sv
// Buffers the store stream and writes it to linear memory; req 1 cycle after accept; holds on !ack.
// Define MPU_STORE_HEADER_EN to write an {M,N} header word at the slot base ahead of the elements.
module mpu_store_writer
    import mpu_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 16,
    parameter int SLOT_WORDS = STORE_SLOT_WORDS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       store_en_in,
    input  logic [FPBITS:0]            store_element_in,
    input  logic [MBITS:0]             m_size_in,
    input  logic [NBITS:0]             n_size_in,
    input  logic [MATRIX_REG_BITS:0]   store_addr_in,
    output logic                       mem_wr_req_out,
    output logic [ADDR_W-1:0]          mem_wr_addr_out,
    output logic [FPBITS:0]            mem_wr_data_out,
    input  logic                       mem_wr_ack_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic                       overflow_err_out,
    output logic                       short_err_out
);
    store_wr_state_t state;

    logic [STORE_TOTAL_W-1:0] total_q;
    logic [STORE_TOTAL_W-1:0] in_cnt;
    logic [STORE_TOTAL_W-1:0] total_in;
    logic [ADDR_W-1:0]        addr_q;
    logic [ADDR_W-1:0]        base_in;
    logic                     ovf_q;
    logic                     short_q;
    logic                     hdr_pend;
    logic                     start;
    logic                     zero_size;
    logic                     in_stream;
    logic                     active;
    logic                     wr_fire;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FPBITS:0]          fifo_rd;
    logic [$clog2(DEPTH):0]   fifo_count;

    assign start     = (state == SW_IDLE) && store_en_in;
    assign zero_size = (m_size_in == '0) || (n_size_in == '0);
    assign total_in  = store_total(m_size_in, n_size_in);
    assign base_in   = ADDR_W'(store_addr_in) * ADDR_W'(SLOT_WORDS);
    assign in_stream = (state == SW_STREAM) && store_en_in;
    assign active    = (state == SW_STREAM) || (state == SW_DRAIN);
    assign fifo_push = (start && !zero_size) || in_stream;

    assign mem_wr_req_out  = active && (hdr_pend || !fifo_empty);
    assign wr_fire         = mem_wr_req_out && mem_wr_ack_in;
    assign fifo_pop        = wr_fire && !hdr_pend;
    assign mem_wr_addr_out = addr_q;

    assign busy_out         = (state != SW_IDLE);
    assign done_out         = (state == SW_DONE);
    assign overflow_err_out = ovf_q;
    assign short_err_out    = short_q;

`ifdef MPU_STORE_HEADER_EN
    localparam bit HDR_EN = 1'b1;
    logic [FPBITS:0] hdr_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hdr_pend <= 1'b0;
            hdr_word <= '0;
        end else if (start) begin
            hdr_pend <= 1'b1;
            hdr_word <= (FPBITS+1)'({m_size_in, n_size_in});
        end else if (wr_fire) begin
            hdr_pend <= 1'b0;
        end
    end

    assign mem_wr_data_out = hdr_pend ? hdr_word : fifo_rd;
`else
    localparam bit HDR_EN = 1'b0;
    assign hdr_pend        = 1'b0;
    assign mem_wr_data_out = fifo_rd;
`endif

    mpu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FPBITS + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (store_element_in),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= SW_IDLE;
            total_q <= '0;
            in_cnt  <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
        end else begin
            if (wr_fire) addr_q <= addr_q + ADDR_W'(1);
            unique case (state)
                SW_IDLE: begin
                    if (store_en_in) begin
                        total_q <= total_in;
                        in_cnt  <= STORE_TOTAL_W'(1);
                        addr_q  <= base_in;
                        ovf_q   <= 1'b0;
                        short_q <= 1'b0;
                        // An empty matrix still has to drain its header when one is enabled.
                        if (zero_size)                         state <= HDR_EN ? SW_DRAIN : SW_DONE;
                        else if (total_in == STORE_TOTAL_W'(1)) state <= SW_DRAIN;
                        else                                   state <= SW_STREAM;
                    end
                end
                SW_STREAM: begin
                    if (store_en_in) begin
                        in_cnt <= in_cnt + STORE_TOTAL_W'(1);
                        if (fifo_full && !fifo_pop) ovf_q <= 1'b1;
                        if (in_cnt + STORE_TOTAL_W'(1) == total_q) state <= SW_DRAIN;
                    end else begin
                        short_q <= 1'b1;
                        state   <= SW_DRAIN;
                    end
                end
                SW_DRAIN: begin
                    if ((fifo_count == '0) && !hdr_pend) state <= SW_DONE;
                end
                SW_DONE: state <= SW_IDLE;
                default: state <= SW_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpu_store_writer.sv
`timescale 1ns/1ps
module tb_mpu_store_writer;
    import mpu_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 16;
    localparam int SLOT   = 64;
`ifdef MPU_STORE_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     store_en;
    logic [FPBITS:0]          elem;
    logic [MBITS:0]           m_size;
    logic [NBITS:0]           n_size;
    logic [MATRIX_REG_BITS:0] saddr;
    logic                     req;
    logic [ADDR_W-1:0]        waddr;
    logic [FPBITS:0]          wdata;
    logic                     ack;
    logic                     busy;
    logic                     done;
    logic                     ovf;
    logic                     short_err;

    mpu_store_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SLOT_WORDS(SLOT)) dut (
        .clk              (clk),
        .rst              (rst),
        .store_en_in      (store_en),
        .store_element_in (elem),
        .m_size_in        (m_size),
        .n_size_in        (n_size),
        .store_addr_in    (saddr),
        .mem_wr_req_out   (req),
        .mem_wr_addr_out  (waddr),
        .mem_wr_data_out  (wdata),
        .mem_wr_ack_in    (ack),
        .busy_out         (busy),
        .done_out         (done),
        .overflow_err_out (ovf),
        .short_err_out    (short_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    m, n, sa, len, ack_mode, hold, exp_wr, ovf_at;
        bit    exp_ovf, exp_short;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [FPBITS:0]   data;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[8];
    int   pass_cnt = 0, total_cnt = 0;
    int   cyc = 0, start_cyc = 0, ack_mode = 0, hold = 0;
    int   wr_cnt = 0, done_cnt = 0, hold_viol = 0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] paddr;
    logic [FPBITS:0]   pdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string nm, input int m, input int n, input int sa, input int len,
                                input int am, input int hd, input int ew, input bit eo, input bit es,
                                input int oa);
        vec_t v;
        v.name = nm; v.m = m; v.n = n; v.sa = sa; v.len = len; v.ack_mode = am; v.hold = hd;
        v.exp_wr = ew; v.exp_ovf = eo; v.exp_short = es; v.ovf_at = oa;
        return v;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Ack pattern: 0 always, 1 every 4th cycle, 2 low for 'hold' cycles then high.
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       ack = 1'b1;
                1:       ack = ((cyc - start_cyc) % 4) == 3;
                default: ack = (cyc - start_cyc) >= hold;
            endcase
        end
    end

    // Write-port monitor: scoreboard pop on each accepted write, hold-stability tracking.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend && (!req || waddr != paddr || wdata != pdata)) hold_viol++;
                if (req && ack) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected none", waddr, wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 64'(waddr), 64'(e.addr));
                        check("wr_data", 64'(wdata), 64'(e.data));
                    end
                end
                pend  = req && !ack;
                paddr = waddr;
                pdata = wdata;
                if (done) done_cnt++;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [31:0]       r;
        logic [ADDR_W-1:0] base;
        int                hv0;
        wr_t               w;
        wr_cnt = 0; done_cnt = 0; hv0 = hold_viol;
        ack_mode = v.ack_mode; hold = v.hold; start_cyc = cyc;
        base = ADDR_W'(v.sa * SLOT);
        if (HDR != 0) begin
            w.addr = base;
            w.data = (FPBITS+1)'({4'(v.m), 4'(v.n)});
            exp_q.push_back(w);
        end
        for (int k = 0; k < v.len; k++) begin
            r = $urandom;
            store_en = 1'b1;
            elem     = r[FPBITS:0];
            m_size   = (MBITS+1)'(v.m);
            n_size   = (NBITS+1)'(v.n);
            saddr    = (MATRIX_REG_BITS+1)'(v.sa);
            if (k < v.exp_wr) begin
                w.addr = base + ADDR_W'(HDR + k);
                w.data = elem;
                exp_q.push_back(w);
            end
            @(posedge clk);
            #1;
            if (v.ovf_at >= 0 && (k == v.ovf_at - 1 || k == v.ovf_at))
                check({v.name, "_ovf_edge"}, 64'(ovf), 64'(k >= v.ovf_at));
        end
        store_en = 1'b0;
        for (int t = 0; t < 600 && done_cnt == 0; t++) @(posedge clk);
        if (done_cnt == 0) begin
            total_cnt++;
            $display("FAIL %s_done_timeout: got no done, expected done pulse", v.name);
        end
        repeat (3) @(posedge clk);
        #1;
        check({v.name, "_done_once"}, 64'(done_cnt), 64'(1));
        check({v.name, "_wr_count"},  64'(wr_cnt),   64'(v.exp_wr + HDR));
        check({v.name, "_q_empty"},   64'(exp_q.size()), 64'(0));
        check({v.name, "_overflow"},  64'(ovf),      64'(v.exp_ovf));
        check({v.name, "_short"},     64'(short_err), 64'(v.exp_short));
        check({v.name, "_busy_idle"}, 64'(busy),     64'(0));
        check({v.name, "_hold"},      64'(hold_viol - hv0), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        vecs[0] = mk("m2n3",     2, 3, 1,  6, 0,  0,  6, 0, 0, -1);
        vecs[1] = mk("m4n4_ack4",4, 4, 0, 16, 1,  0, 16, 0, 0, -1);
        vecs[2] = mk("m5n5_ovf", 5, 5, 0, 25, 2, 30, 16, 1, 0, 16);
        vecs[3] = mk("short5",   3, 3, 0,  5, 0,  0,  5, 0, 1, -1);
        vecs[4] = mk("extra_ign",1, 2, 3,  3, 1,  0,  2, 0, 0, -1);
        vecs[5] = mk("zero_m",   0, 3, 2,  1, 0,  0,  0, 0, 0, -1);
        vecs[6] = mk("m2n2_s2",  2, 2, 2,  4, 0,  0,  4, 0, 0, -1);
        vecs[7] = mk("m1n1_s7",  1, 1, 7,  1, 0,  0,  1, 0, 0, -1);

        rst = 1'b0; store_en = 1'b0; elem = '0; m_size = '0; n_size = '0; saddr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   64'(req),       64'(0));
        check("rst_busy",  64'(busy),      64'(0));
        check("rst_done",  64'(done),      64'(0));
        check("rst_ovf",   64'(ovf),       64'(0));
        check("rst_short", 64'(short_err), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of DRAIN with three words still queued.
        ack_mode = 2; hold = 1_000_000; start_cyc = cyc;
        for (int k = 0; k < 3; k++) begin
            r = $urandom;
            store_en = 1'b1; elem = r[FPBITS:0];
            m_size = 4'd2; n_size = 4'd3; saddr = 3'd0;
            @(posedge clk);
            #1;
        end
        store_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("drain_busy",  64'(busy),      64'(1));
        check("drain_req",   64'(req),       64'(1));
        check("drain_short", 64'(short_err), 64'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_req",   64'(req),       64'(0));
        check("midrst_busy",  64'(busy),      64'(0));
        check("midrst_ovf",   64'(ovf),       64'(0));
        check("midrst_short", 64'(short_err), 64'(0));
        check("midrst_done",  64'(done),      64'(0));
        rst = 1'b1;
        ack_mode = 0;
        @(posedge clk);
        #1;
        run_vec(mk("after_rst", 1, 1, 5, 1, 0, 0, 1, 0, 0, -1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/mpu_store_writer.md
Name: mpu_store_writer

Overview:
Downstream stage of the matrix store unit. It consumes the unthrottled one-element-per-cycle store stream (store enable, element, M/N sizes, matrix register address) and buffers it in a FIFO. It then writes each element to external memory at a linear word address over a req/ack handshake. It absorbs memory backpressure, flags overflow or short streams, and pulses done when the whole matrix has been committed.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 4.
ADDR_W, 16, external memory word-address width.
SLOT_WORDS, 64, words reserved per matrix register slot; base = store_addr_in * SLOT_WORDS.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-low (0 = reset).
store_en_in  in  1  stream valid; one element per cycle while high.
store_element_in  in  FPBITS+1  matrix element, row-major order.
m_size_in  in  MBITS+1  total rows M; sampled on the first accepted cycle.
n_size_in  in  NBITS+1  total columns N; sampled on the first accepted cycle.
store_addr_in  in  MATRIX_REG_BITS+1  source matrix register; sampled on the first cycle.
mem_wr_req_out  out  1  write request.
mem_wr_addr_out  out  ADDR_W  word address.
mem_wr_data_out  out  FPBITS+1  write data.
mem_wr_ack_in  in  1  memory accepts the current request this cycle.
busy_out  out  1  high from stream start until done.
done_out  out  1  one-cycle pulse after the last write is acked.
overflow_err_out  out  1  sticky; an element arrived while the FIFO was full.
short_err_out  out  1  sticky; the stream ended before M*N elements.

Behaviour:
- Reset (rst=0 at an edge): FSM returns to IDLE; FIFO is emptied; counters are cleared; all outputs are 0, including sticky errors. Reset mid-transfer abandons the transfer and issues no further req.
- States: IDLE, STREAM, DRAIN, DONE.
  - IDLE -> STREAM when store_en_in=1. That cycle's element is accepted, and M, N and base are latched. Total = M*N, computed at width MBITS+NBITS+2.
  - In STREAM, each cycle with store_en_in=1 pushes one element and increments the in-count.
  - STREAM -> DRAIN when the in-count reaches Total. Any further store_en_in in DRAIN is ignored and is not an error.
  - STREAM -> DRAIN when store_en_in falls before Total. short_err_out is set.
  - DRAIN -> DONE when the FIFO is empty and no req is outstanding.
  - DONE asserts done_out for one cycle, then goes to IDLE.
- M=0 or N=0 latched: go straight to DONE and issue no writes. The first element is discarded.
- Write port:
  - mem_wr_req_out=1 whenever the FIFO is non-empty, in STREAM or DRAIN.
  - Address and data are held stable while req=1 and ack=0.
  - ack with req pops the entry and advances the address by 1. The next entry may be presented in the following cycle, so back-to-back one-cycle writes are possible.
  - ack without req is ignored.
  - Minimum latency from the accept cycle to req is 1 cycle, because the FIFO output is registered.
- Address: element k (0-based, row-major, k = i*N + j) goes to base + k, truncated to ADDR_W. Wrap modulo 2^ADDR_W is permitted and not flagged.
- FIFO full with store_en_in=1: the element is dropped and overflow_err_out is set. The in-count still increments, so termination is unaffected.
- A push and a pop in the same cycle on a full FIFO are legal. The pop frees the slot, so there is no overflow.
- busy_out = (state != IDLE).
- Sticky errors clear only on reset or on the next IDLE->STREAM transition.

Optional Feature:
MPU_STORE_HEADER_EN:
- Defined: before any element, one header word is written at base. The header data is {M,N} zero-extended to FPBITS+1, with N in the LSBs. Elements then go to base + 1 + k. The header is injected at the write port ahead of the FIFO head. done_out requires the header ack as well, and the M=0/N=0 case still writes the header.
- Undefined: no header is written; addressing is as described above.

Decomposition:
- Shared package (mpu_pkg): store_wr_state_t enum {SW_IDLE, SW_STREAM, SW_DRAIN, SW_DONE}; a STORE_SLOT_WORDS default constant.
- Widths come from global_defs.
- One sub-module: mpu_sync_fifo, parameterised by DEPTH and width, with push/pop/full/empty/count and a registered read data output. It can be reused by a future load path.

Test Plan:
1. M=2, N=3, store_addr=1, ack tied 1 -> 6 writes to addresses 64..69 with data in stream order; done_out pulses once; no errors.
2. M=4, N=4, store_addr=0, ack only every 4th cycle, DEPTH=16 -> 16 writes to 0..15, each held stable until ack; no overflow.
3. M=5, N=5, ack held 0 for 30 cycles, DEPTH=16 -> overflow_err_out=1 from element 17; exactly 16 writes after ack resumes; done_out still pulses.
4. M=3, N=3, store_en_in drops after 5 elements -> short_err_out=1; 5 writes; done_out pulses.
5. rst=0 asserted mid-DRAIN with 3 entries queued -> next cycle req=0, busy=0, errors=0; a new M=1, N=1 stream completes normally.
6. With MPU_STORE_HEADER_EN, M=2, N=2, store_addr=2 -> header {2,2} written at 128, elements at 129..132, then done_out.
